// File: rtl/multdiv_seq_pkg.sv
// Shared constants, state encoding and decode helper for the sequential
// multiply/divide issue controller.
package multdiv_seq_pkg;

    localparam logic [4:0]  OPC_RTYPE   = 5'b00000;
    localparam logic [4:0]  ALUOP_MUL   = 5'b00110;
    localparam logic [4:0]  ALUOP_DIV   = 5'b00111;
    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MUL     = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;
    localparam logic [31:0] EXC_TIMEOUT = 32'd6;
    localparam int unsigned CNT_W       = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WB    = 2'b11
    } md_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_e;

    function automatic logic is_md_op(input logic valid, input logic [4:0] opcode,
                                      input logic [4:0] aluop);
        return valid && (opcode == OPC_RTYPE) &&
               ((aluop == ALUOP_MUL) || (aluop == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/multdiv_seq_if.sv
// Handshake bus between the issue controller (master) and the
// multiplier/divider unit (slave).
interface multdiv_seq_if;

    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;

    modport master (
        output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
        input  md_result, md_exception, md_ready
    );

    modport slave (
        input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
        output md_result, md_exception, md_ready
    );

endinterface

// File: rtl/md_timeout_ctr.sv
// WAIT-cycle counter: cleared while issuing, counts each WAIT cycle and flags
// the last permitted cycle so the controller can abort the operation.
module md_timeout_ctr
    import multdiv_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + ONE_CNT;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/multdiv_seq.sv
// Decode-stage controller that issues MUL/DIV to an external unit, stalls the
// front end while it runs, and writes back the result or an error code.
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid_i,
    input  logic [4:0]          opcode_i,
    input  logic [4:0]          aluop_i,
    input  logic [4:0]          rd_i,
    input  logic [31:0]         operand_a_i,
    input  logic [31:0]         operand_b_i,
    multdiv_seq_if.master       md,
    output logic                stall_o,
    output logic                wb_we_o,
    output logic [4:0]          wb_rd_o,
    output logic [31:0]         wb_data_o,
    output logic                busy_o
);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        busy_q;
    logic        md_op_s;
    logic        timeout_s;

    assign md_op_s = is_md_op(op_valid_i, opcode_i, aluop_i);

    md_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .timeout_o (timeout_s)
    );

    // next state, latched operands and registered outputs
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        mult_d    = 1'b0;
        div_d     = 1'b0;
        wb_we_d   = 1'b0;
        wb_rd_d   = 5'd0;
        wb_data_d = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (md_op_s) begin
                    state_d = ST_ISSUE;
                    op_d    = (aluop_i == ALUOP_DIV) ? OP_DIV : OP_MUL;
                    rd_d    = rd_i;
                    opa_d   = operand_a_i;
                    opb_d   = operand_b_i;
                    mult_d  = (aluop_i == ALUOP_MUL);
                    div_d   = (aluop_i == ALUOP_DIV);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // a ready seen here belongs to an earlier request and is dropped
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (md.md_ready) begin
                    state_d = ST_WB;
                    wb_we_d = 1'b1;
                    if (md.md_exception) begin
                        wb_rd_d   = RSTATUS_REG;
                        wb_data_d = (op_q == OP_DIV) ? EXC_DIV : EXC_MUL;
                    end else begin
                        wb_rd_d   = rd_q;
                        wb_data_d = md.md_result;
                    end
                end else if (timeout_s) begin
                    state_d   = ST_WB;
                    wb_we_d   = 1'b1;
                    wb_rd_d   = RSTATUS_REG;
                    wb_data_d = EXC_TIMEOUT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                op_d    = OP_MUL;
                rd_d    = 5'd0;
                opa_d   = 32'd0;
                opb_d   = 32'd0;
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = OP_MUL;
                rd_d    = 5'd0;
                opa_d   = 32'd0;
                opb_d   = 32'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // operand latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_MUL;
            rd_q      <= 5'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            mult_q    <= 1'b0;
            div_q     <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            op_q      <= op_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            mult_q    <= mult_d;
            div_q     <= div_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign md.md_ctrl_mult = mult_q;
    assign md.md_ctrl_div  = div_q;
    assign md.md_operand_a = opa_q;
    assign md.md_operand_b = opb_q;
    assign wb_we_o         = wb_we_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_data_o       = wb_data_q;
    assign busy_o          = busy_q;
    // stall must reach decode in the accept cycle, so it cannot be registered
    assign stall_o         = rst_n && ((state_q != ST_IDLE) || md_op_s);

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: the bench plays the mul/div unit and checks
// writebacks against a scoreboard of expected {rd, data} pairs.
module tb_multdiv_seq;
    import multdiv_seq_pkg::*;

    localparam int unsigned TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid_i;
    logic [4:0]  opcode_i, aluop_i, rd_i;
    logic [31:0] operand_a_i, operand_b_i;
    logic        stall_o, wb_we_o, busy_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    multdiv_seq_if md_if ();

    multdiv_seq #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid_i  (op_valid_i),
        .opcode_i    (opcode_i),
        .aluop_i     (aluop_i),
        .rd_i        (rd_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .md          (md_if.master),
        .stall_o     (stall_o),
        .wb_we_o     (wb_we_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t     sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          mult_cnt = 0, div_cnt = 0, wb_cnt = 0, stall_cnt = 0;
    int          b_mult, b_div, b_wb, b_stall;
    int          cyc;
    logic [4:0]  cur_rd;
    logic        cur_mul;

    // event counters sampled on the falling edge
    always @(negedge clk) begin
        if (md_if.md_ctrl_mult === 1'b1) mult_cnt++;
        if (md_if.md_ctrl_div === 1'b1) div_cnt++;
        if (wb_we_o === 1'b1) wb_cnt++;
        if (stall_o === 1'b1) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        #1;
        b_mult = mult_cnt; b_div = div_cnt; b_wb = wb_cnt; b_stall = stall_cnt;
    endtask

    task automatic check_deltas(input string tag, input int m, input int d, input int w);
        #1;
        check({tag, " mult pulses"}, 32'(mult_cnt - b_mult), 32'(m));
        check({tag, " div pulses"}, 32'(div_cnt - b_div), 32'(d));
        check({tag, " wb writes"}, 32'(wb_cnt - b_wb), 32'(w));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " stall"}, 32'(stall_o), 32'd0);
        check({tag, " busy"}, 32'(busy_o), 32'd0);
        check({tag, " wb_we"}, 32'(wb_we_o), 32'd0);
        check({tag, " wb_rd"}, 32'(wb_rd_o), 32'd0);
        check({tag, " wb_data"}, wb_data_o, 32'd0);
        check({tag, " pulses"}, 32'({md_if.md_ctrl_mult, md_if.md_ctrl_div}), 32'd0);
        check({tag, " opa"}, md_if.md_operand_a, 32'd0);
        check({tag, " opb"}, md_if.md_operand_b, 32'd0);
    endtask

    // accept cycle then ISSUE cycle; returns at the ISSUE sample point
    task automatic drive_op(input logic [4:0] aluop, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic stale_rdy, input logic keep_valid,
                            input logic [4:0] next_aluop);
        next_cycle();
        op_valid_i = 1'b1; opcode_i = OPC_RTYPE; aluop_i = aluop; rd_i = rd;
        operand_a_i = a; operand_b_i = b;
        cur_rd = rd; cur_mul = (aluop == ALUOP_MUL);
        @(negedge clk);
        check("accept stall", 32'(stall_o), 32'd1);
        check("accept no pulse", 32'({md_if.md_ctrl_mult, md_if.md_ctrl_div}), 32'd0);
        next_cycle();
        op_valid_i = keep_valid; aluop_i = next_aluop; rd_i = 5'd31;
        operand_a_i = 32'hFFFF_FFFF; operand_b_i = 32'hFFFF_FFFF;
        md_if.md_ready = stale_rdy; md_if.md_result = 32'h0BAD_0BAD;
        @(negedge clk);
        check("issue mult", 32'(md_if.md_ctrl_mult), 32'(cur_mul));
        check("issue div", 32'(md_if.md_ctrl_div), 32'(!cur_mul));
        check("issue opa", md_if.md_operand_a, a);
        check("issue opb", md_if.md_operand_b, b);
        check("issue busy", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_n(input int n);
        repeat (n) begin
            next_cycle();
            md_if.md_ready = 1'b0; md_if.md_exception = 1'b0;
        end
    endtask

    task automatic set_ready(input logic [31:0] result, input logic exc);
        wb_exp_t e;
        next_cycle();
        md_if.md_ready = 1'b1; md_if.md_result = result; md_if.md_exception = exc;
        e.rd   = exc ? RSTATUS_REG : cur_rd;
        e.data = exc ? (cur_mul ? 32'd4 : 32'd5) : result;
        sb_q.push_back(e);
    endtask

    task automatic push_timeout();
        wb_exp_t e;
        e.rd = 5'd30; e.data = 32'd6;
        sb_q.push_back(e);
    endtask

    task automatic wait_wb(input string tag, input int budget, output int cycles);
        wb_exp_t e;
        bit seen;
        seen = 1'b0; cycles = 0;
        while (!seen && cycles < budget) begin
            next_cycle();
            md_if.md_ready = 1'b0; md_if.md_exception = 1'b0;
            @(negedge clk);
            cycles++;
            if (wb_we_o === 1'b1) seen = 1'b1;
        end
        check({tag, " wb seen"}, 32'(seen), 32'd1);
        check({tag, " sb nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (seen && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, " wb_rd"}, 32'(wb_rd_o), 32'(e.rd));
            check({tag, " wb_data"}, wb_data_o, e.data);
        end
    endtask

    task automatic go_idle(input string tag);
        next_cycle();
        @(negedge clk);
        check_all_zero(tag);
    endtask

    initial begin
        op_valid_i = 1'b0; opcode_i = 5'd0; aluop_i = 5'd0; rd_i = 5'd0;
        operand_a_i = 32'd0; operand_b_i = 32'd0;
        md_if.md_ready = 1'b0; md_if.md_exception = 1'b0; md_if.md_result = 32'd0;

        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // MUL 7 x 6 -> 42, ready 10 cycles after the pulse
        snap();
        drive_op(ALUOP_MUL, 5'd3, 32'd7, 32'd6, 1'b0, 1'b0, ALUOP_MUL);
        wait_n(9);
        set_ready(32'd42, 1'b0);
        wait_wb("mul42", 20, cyc);
        check("mul42 latency", 32'(cyc), 32'd1);
        go_idle("mul42 idle");
        check_deltas("mul42", 1, 0, 1);
        check("mul42 stall cycles", 32'(stall_cnt - b_stall), 32'd13);

        // DIV with exception -> r30 = 5
        snap();
        drive_op(ALUOP_DIV, 5'd9, 32'd100, 32'd0, 1'b0, 1'b0, ALUOP_MUL);
        wait_n(2);
        set_ready(32'hDEAD_BEEF, 1'b1);
        wait_wb("divexc", 20, cyc);
        go_idle("divexc idle");
        check_deltas("divexc", 0, 1, 1);

        // MUL with no ready -> timeout after 40 WAIT cycles
        snap();
        drive_op(ALUOP_MUL, 5'd4, 32'd1, 32'd2, 1'b0, 1'b0, ALUOP_MUL);
        push_timeout();
        wait_wb("timeout", 60, cyc);
        check("timeout cycles", 32'(cyc), 32'(TMO + 1));
        go_idle("timeout idle");
        check_deltas("timeout", 1, 0, 1);

        // ready arriving in the timeout cycle wins
        drive_op(ALUOP_MUL, 5'd12, 32'd5, 32'd11, 1'b0, 1'b0, ALUOP_MUL);
        wait_n(TMO - 1);
        set_ready(32'd55, 1'b0);
        wait_wb("rdy_vs_tmo", 5, cyc);
        check("rdy_vs_tmo latency", 32'(cyc), 32'd1);
        go_idle("rdy_vs_tmo idle");

        // stale ready in ISSUE ignored, second ready used
        snap();
        drive_op(ALUOP_MUL, 5'd5, 32'd3, 32'd3, 1'b1, 1'b0, ALUOP_MUL);
        wait_n(1);
        @(negedge clk);
        check("stale no wb", 32'(wb_we_o), 32'd0);
        check("stale busy", 32'(busy_o), 32'd1);
        wait_n(3);
        set_ready(32'd9, 1'b0);
        wait_wb("stale", 5, cyc);
        check("stale latency", 32'(cyc), 32'd1);
        go_idle("stale idle");
        check_deltas("stale", 1, 0, 1);

        // reset during WAIT aborts; late ready ignored; next MUL normal
        snap();
        drive_op(ALUOP_MUL, 5'd7, 32'd2, 32'd2, 1'b0, 1'b0, ALUOP_MUL);
        wait_n(2);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst in wait");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        md_if.md_ready = 1'b1; md_if.md_result = 32'd77;
        wait_n(3);
        @(negedge clk);
        check_all_zero("late ready");
        check_deltas("rst abort", 1, 0, 0);
        drive_op(ALUOP_MUL, 5'd8, 32'd2, 32'd21, 1'b0, 1'b0, ALUOP_MUL);
        wait_n(2);
        set_ready(32'd42, 1'b0);
        wait_wb("post rst mul", 5, cyc);
        go_idle("post rst idle");

        // DIV to rd 0 still writes back
        drive_op(ALUOP_DIV, 5'd0, 32'd9, 32'd3, 1'b0, 1'b0, ALUOP_MUL);
        wait_n(1);
        set_ready(32'd3, 1'b0);
        wait_wb("rd0", 5, cyc);
        go_idle("rd0 idle");

        // MUL followed by ADD held on op_valid
        snap();
        drive_op(ALUOP_MUL, 5'd10, 32'd5, 32'd5, 1'b0, 1'b1, 5'b00000);
        wait_n(1);
        set_ready(32'd25, 1'b0);
        wait_wb("b2b", 5, cyc);
        go_idle("b2b after wb");
        next_cycle();
        @(negedge clk);
        check("b2b add busy", 32'(busy_o), 32'd0);
        check("b2b add stall", 32'(stall_o), 32'd0);
        next_cycle();
        op_valid_i = 1'b0;
        check_deltas("b2b", 1, 0, 1);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter TIMEOUT, default 40, is the maximum number of WAIT cycles before an operation is aborted.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op_valid  input  1  decode-stage instruction valid.
REQ-005 opcode  input  5  instruction opcode; R-type is 00000.
REQ-006 aluop  input  5  R-type ALU op field; MUL = 00110, DIV = 00111.
REQ-007 rd  input  5  destination register of decode instruction.
REQ-008 operand_a, operand_b  input  32 each  source operand values.
REQ-009 md_ctrl_mult, md_ctrl_div  output  1 each  one-cycle start pulses to the multiplier/divider unit.
REQ-010 md_operand_a, md_operand_b  output  32 each  latched operands to the unit.
REQ-011 md_result  input  32  unit result.
REQ-012 md_exception  input  1  unit exception (overflow, divide-by-zero), valid with md_ready.
REQ-013 md_ready  input  1  unit result valid, single-cycle pulse.
REQ-014 stall  output  1  freezes fetch/decode while high.
REQ-015 wb_we  output  1  register-file write enable for this block's result.
REQ-016 wb_rd  output  5  writeback register index.
REQ-017 wb_data  output  32  writeback value.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 md_op is decoded as op_valid && opcode == 00000 && aluop in {MUL, DIV}; other ops are ignored.
REQ-020 FSM states are IDLE, ISSUE, WAIT, WB; transitions: IDLE->ISSUE on md_op; ISSUE->WAIT unconditionally; WAIT->WB on md_ready or timeout; WB->IDLE unconditionally.
REQ-021 On the IDLE accept edge, the block latches operand_a, operand_b, rd and the op type (mul/div).
REQ-022 In ISSUE only, exactly one of md_ctrl_mult/md_ctrl_div is 1, per the latched op type.
REQ-023 md_operand_a/b hold the latched values from ISSUE through WB and are 0 in IDLE.
REQ-024 stall = (state != IDLE) || (state == IDLE && md_op), combinational.
REQ-025 stall deasserts in the cycle after WB, so minimum total stall for an operation is 4 cycles.
REQ-026 md_ready in ISSUE is stale and is ignored; only md_ready in WAIT is accepted.
REQ-027 A 6-bit wait counter clears on entering WAIT and increments each WAIT cycle; timeout = counter reaches TIMEOUT-1 without md_ready.
REQ-028 md_ready and timeout in the same cycle: md_ready wins.
REQ-029 The result/exception flag are registered on the WAIT->WB edge; wb_we = 1 only in WB.
REQ-030 Normal result: wb_rd = latched rd, wb_data = md_result.
REQ-031 md_exception: wb_rd = 30, wb_data = 4 for MUL, 5 for DIV.
REQ-032 Timeout: wb_rd = 30, wb_data = 6.
REQ-033 Outside WB, wb_we = 0, wb_rd = 0, wb_data = 0.
REQ-034 op_valid in any non-IDLE state is ignored; the pipeline re-presents it after stall drops.
REQ-035 Writes to rd = 0 still perform the handshake; wb_we is asserted, and the register file discards the write.

Reset
REQ-036 reset low asynchronously forces IDLE, counter 0, latches 0, and all outputs 0, including stall and busy.
REQ-037 Reset in ISSUE/WAIT/WB aborts the operation with no writeback; a late md_ready after reset release is ignored in IDLE.

Structure
REQ-038 A shared package holds constants OPC_RTYPE, ALUOP_MUL, ALUOP_DIV, RSTATUS_REG = 30, EXC_MUL = 4, EXC_DIV = 5, EXC_TIMEOUT = 6, and the state encoding.
REQ-039 The wait counter plus its timeout compare is one sub-module, md_timeout_ctr.

Verification
REQ-040 MUL 7 x 6, rd = 3, md_ready 10 cycles after the pulse with result 42 -> one md_ctrl_mult pulse; one wb_we with rd 3, data 42; stall high exactly from accept through WB.
REQ-041 DIV with md_exception = 1 at ready -> wb_we, wb_rd = 30, wb_data = 5; no write to the original rd.
REQ-042 MUL with md_ready never asserted -> after 40 WAIT cycles, WB with rd 30, data 6; FSM returns to IDLE.
REQ-043 md_ready pulsed during ISSUE, then again 5 cycles later -> only the second pulse is used; the first causes no WB.
REQ-044 reset driven low in WAIT, then md_ready after release -> no wb_we; all outputs 0; next MUL runs normally.
REQ-045 Back-to-back MUL then ADD on op_valid -> ADD produces no pulse, stall drops the cycle after WB, and no spurious second issue occurs.
